race_control: RTL and testbench
===============================

RACE_CONTROL -- requirements
Module: race_control

Interface
REQ-001 Parameter TICK_DIV, default 65000: clk cycles per 1 ms tick (65 MHz pixel clock).
REQ-002 Parameter LIGHT_MS, default 1000: ms between countdown light steps.
REQ-003 Parameter MOVE_MS, default 20: ms between position updates.
REQ-004 Parameter X_START, default 256: car start x coordinate.
REQ-005 Parameter TRACK_END, default 900: finish x coordinate.
REQ-006 Parameter MAX_SPEED, default 7: speed saturation value.
REQ-007 Port clk, input, 1: single clock; one clock, all logic in this domain.
REQ-008 Port reset, input, 1: reset, asynchronous, active-high.
REQ-009 Port start_game, input, 1: one-cycle pulse from game menu, begins a race.
REQ-010 Port abort, input, 1: one-cycle pulse, return to idle.
REQ-011 Ports p1_key and p2_key, input, 1 each: one-cycle key rising-edge pulses.
REQ-012 Ports xpos_p1 and xpos_p2, output, 11 each: car x positions for the car drawing stages.
REQ-013 Port lights, output, 3: count of lit start lights, 0..3.
REQ-014 Port green, output, 1: high while racing.
REQ-015 Port state, output, 2: 0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISH.
REQ-016 Port winner, output, 2: 0 none, 1 P1, 2 P2, 3 tie.
REQ-017 Ports false_start_p1 and false_start_p2, output, 1 each: sticky per-race flags.
REQ-018 Port race_ms, output, 16: elapsed race time in ms.

Function
REQ-019 ms tick: free-running counter 0..TICK_DIV-1; one-cycle tick at wrap; counter clears on every state entry.
REQ-020 IDLE: outputs hold their reset values; start_game -> COUNTDOWN next cycle.
REQ-021 COUNTDOWN entry: lights=0, positions=X_START, speeds=0, race_ms=0, flags=0, winner=0.
REQ-022 COUNTDOWN: each LIGHT_MS ticks, lights +1; LIGHT_MS ticks after lights reaches 3 -> RACE, with green=1 and lights=3 held.
REQ-023 Key pulse in COUNTDOWN is a false start: set that player's flag, winner = other player, -> FINISH next cycle; both in the same cycle: both flags set, winner=0.
REQ-024 RACE: key pulse increments that player's speed by 1, saturating at MAX_SPEED.
REQ-025 RACE: every MOVE_MS ticks, each xpos += speed, saturating at TRACK_END; use 12-bit intermediate sums, no wrap-around.
REQ-026 RACE: race_ms +1 per tick, saturating at 65535.
REQ-027 First update that puts xpos at TRACK_END sets winner (1 or 2), -> FINISH; both reach it on the same update: winner=3.
REQ-028 FINISH: all outputs frozen, green=0; start_game -> COUNTDOWN (full re-init per REQ-021).
REQ-029 abort in any state -> IDLE next cycle, with all outputs at reset values; abort beats a simultaneous start_game.
REQ-030 Key pulses in IDLE and FINISH are ignored.
REQ-031 All outputs are registered; xpos is updated one cycle after the tick.

Reset
REQ-032 reset asserted: immediate asynchronous clear; state=IDLE, xpos=X_START, lights=0, green=0, winner=0, flags=0, race_ms=0, speeds=0, tick counter=0.
REQ-033 Reset mid-race aborts the race; no start_game pulse is remembered across reset.

Verification (TICK_DIV=4, LIGHT_MS=3, MOVE_MS=2, X_START=256, TRACK_END=280, MAX_SPEED=7)
REQ-034 Countdown: start_game pulse -> lights 0,1,2,3 every 12 cycles; green=1, state=2 at 48 cycles.
REQ-035 Race: in RACE, send 3 p1_key pulses and 1 p2_key pulse -> xpos_p1 +3 and xpos_p2 +1 per 8 cycles; P1 reaches 280, winner=1, state=3, race_ms frozen.
REQ-036 False start: p2_key during lights=1 -> false_start_p2=1, winner=1, state=3; xpos both 256.
REQ-037 Saturation and tie: 10 pulses each player -> speed 7 both; both reach 280 on the same update -> winner=3, xpos=280 (no overshoot).
REQ-038 Abort and restart: abort and start_game in the same cycle during RACE -> IDLE; a following start_game re-enters COUNTDOWN with all values re-initialised.
REQ-039 Reset: assert reset asynchronously mid-RACE -> all outputs at reset values within the same cycle; after release, state=0 until start_game.

Source files
------------

// File: rtl/race_control_if.sv
// race_control_if
//   Groups the game-menu/keyboard pulses and the race status outputs of
//   race_control into one bundle.
//   master : the side that drives start_game/abort/p1_key/p2_key and reads
//            the car positions, lights and result (menu, keyboard, bench).
//   slave  : race_control itself.
//   Signals:
//     start_game, abort, p1_key, p2_key  one-cycle pulses into the race
//     xpos_p1, xpos_p2                   car x positions (11 bit)
//     lights                             number of lit start lights 0..3
//     green                              high while racing
//     state                              0 idle, 1 countdown, 2 race, 3 finish
//     winner                             0 none, 1 P1, 2 P2, 3 tie
//     false_start_p1/p2                  sticky per-race false start flags
//     race_ms                            elapsed race time in ms
interface race_control_if;
  logic        start_game;
  logic        abort;
  logic        p1_key;
  logic        p2_key;
  logic [10:0] xpos_p1;
  logic [10:0] xpos_p2;
  logic [2:0]  lights;
  logic        green;
  logic [1:0]  state;
  logic [1:0]  winner;
  logic        false_start_p1;
  logic        false_start_p2;
  logic [15:0] race_ms;

  modport master (
    output start_game, abort, p1_key, p2_key,
    input  xpos_p1, xpos_p2, lights, green, state, winner,
           false_start_p1, false_start_p2, race_ms
  );

  modport slave (
    input  start_game, abort, p1_key, p2_key,
    output xpos_p1, xpos_p2, lights, green, state, winner,
           false_start_p1, false_start_p2, race_ms
  );
endinterface

// File: rtl/race_control.sv
// race_control
//   Two-player drag race controller: start-light countdown, key-driven car
//   speeds, periodic position updates, finish/false-start detection and a
//   race timer. Everything runs from a 1 ms tick derived from clk.
//   Ports:
//     clk    single clock
//     reset  asynchronous, active-high clear of all state
//     bus    race_control_if.slave (pulses in, status and positions out)
module race_control #(
  parameter int TICK_DIV  = 65000,
  parameter int LIGHT_MS  = 1000,
  parameter int MOVE_MS   = 20,
  parameter int X_START   = 256,
  parameter int TRACK_END = 900,
  parameter int MAX_SPEED = 7
) (
  input  logic          clk,
  input  logic          reset,
  race_control_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX = (LIGHT_MS > MOVE_MS) ? LIGHT_MS : MOVE_MS;
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int SPD_W  = (MAX_SPEED > 1) ? $clog2(MAX_SPEED + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   LIGHT_LAST = MS_W'(LIGHT_MS - 1);
  localparam logic [MS_W-1:0]   MOVE_LAST  = MS_W'(MOVE_MS - 1);
  localparam logic [SPD_W-1:0]  SPD_MAX    = SPD_W'(MAX_SPEED);
  localparam logic [10:0]       X_INIT     = 11'(X_START);
  localparam logic [10:0]       X_END      = 11'(TRACK_END);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic               move_q, move_d;
  logic [2:0]         lights_q, lights_d;
  logic               green_q, green_d;
  logic [1:0]         winner_q, winner_d;
  logic               fs1_q, fs1_d;
  logic               fs2_q, fs2_d;
  logic [15:0]        race_ms_q, race_ms_d;
  logic [10:0]        x1_q, x1_d;
  logic [10:0]        x2_q, x2_d;
  logic [SPD_W-1:0]   sp1_q, sp1_d;
  logic [SPD_W-1:0]   sp2_q, sp2_d;

  logic        tick;
  logic        load_init;
  logic [11:0] sum1, sum2;
  logic        hit1, hit2;

  // 1 ms tick and candidate positions; the 12-bit sums keep a car near the
  // top of the 11-bit range from wrapping past the finish line.
  always_comb begin
    tick = (tick_cnt_q == TICK_LAST);
    sum1 = {1'b0, x1_q} + 12'(sp1_q);
    sum2 = {1'b0, x2_q} + 12'(sp2_q);
    hit1 = (sum1 >= {1'b0, X_END});
    hit2 = (sum2 >= {1'b0, X_END});
  end

  // Next-state logic. The ms counter is shared: it counts ticks between
  // light steps in COUNTDOWN and between position updates in RACE. A
  // position update is flagged on the tick (move_q) and applied one cycle
  // later. Abort and any state change are applied last so they override.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    ms_cnt_d   = ms_cnt_q;
    move_d     = 1'b0;
    lights_d   = lights_q;
    green_d    = green_q;
    winner_d   = winner_q;
    fs1_d      = fs1_q;
    fs2_d      = fs2_q;
    race_ms_d  = race_ms_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    sp1_d      = sp1_q;
    sp2_d      = sp2_q;
    load_init  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_game) begin
          state_d   = COUNTDOWN;
          load_init = 1'b1;
        end
      end

      COUNTDOWN: begin
        if (bus.p1_key || bus.p2_key) begin
          fs1_d    = bus.p1_key;
          fs2_d    = bus.p2_key;
          winner_d = (bus.p1_key && bus.p2_key) ? 2'd0 :
                     (bus.p1_key ? 2'd2 : 2'd1);
          state_d  = FINISH;
        end else if (tick) begin
          if (ms_cnt_q == LIGHT_LAST) begin
            ms_cnt_d = '0;
            if (lights_q == 3'd3) begin
              state_d = RACE;
              green_d = 1'b1;
            end else begin
              lights_d = lights_q + 3'd1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end

      RACE: begin
        if (tick) begin
          if (race_ms_q != 16'hFFFF) begin
            race_ms_d = race_ms_q + 16'd1;
          end
          if (ms_cnt_q == MOVE_LAST) begin
            ms_cnt_d = '0;
            move_d   = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
        if (move_q) begin
          x1_d = hit1 ? X_END : sum1[10:0];
          x2_d = hit2 ? X_END : sum2[10:0];
          // {hit2,hit1} maps directly onto 1=P1, 2=P2, 3=tie
          if (hit1 || hit2) begin
            winner_d = {hit2, hit1};
            green_d  = 1'b0;
            state_d  = FINISH;
          end
        end
        if (bus.p1_key && (sp1_q != SPD_MAX)) begin
          sp1_d = sp1_q + 1'b1;
        end
        if (bus.p2_key && (sp2_q != SPD_MAX)) begin
          sp2_d = sp2_q + 1'b1;
        end
      end

      FINISH: begin
        if (bus.start_game) begin
          state_d   = COUNTDOWN;
          load_init = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d   = IDLE;
      load_init = 1'b1;
    end

    // A new race and an abort both start from the reset values.
    if (load_init) begin
      lights_d  = 3'd0;
      green_d   = 1'b0;
      winner_d  = 2'd0;
      fs1_d     = 1'b0;
      fs2_d     = 1'b0;
      race_ms_d = 16'd0;
      x1_d      = X_INIT;
      x2_d      = X_INIT;
      sp1_d     = '0;
      sp2_d     = '0;
    end

    // Timing restarts from zero in every newly entered state.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      ms_cnt_d   = '0;
      move_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      ms_cnt_q   <= '0;
      move_q     <= 1'b0;
      lights_q   <= 3'd0;
      green_q    <= 1'b0;
      winner_q   <= 2'd0;
      fs1_q      <= 1'b0;
      fs2_q      <= 1'b0;
      race_ms_q  <= 16'd0;
      x1_q       <= X_INIT;
      x2_q       <= X_INIT;
      sp1_q      <= '0;
      sp2_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      move_q     <= move_d;
      lights_q   <= lights_d;
      green_q    <= green_d;
      winner_q   <= winner_d;
      fs1_q      <= fs1_d;
      fs2_q      <= fs2_d;
      race_ms_q  <= race_ms_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      sp1_q      <= sp1_d;
      sp2_q      <= sp2_d;
    end
  end

  assign bus.xpos_p1        = x1_q;
  assign bus.xpos_p2        = x2_q;
  assign bus.lights         = lights_q;
  assign bus.green          = green_q;
  assign bus.state          = state_q;
  assign bus.winner         = winner_q;
  assign bus.false_start_p1 = fs1_q;
  assign bus.false_start_p2 = fs2_q;
  assign bus.race_ms        = race_ms_q;

endmodule

// File: tb/tb_race_control.sv
// tb_race_control
//   Self-checking bench for race_control with small timing parameters.
//   The reference model tracks the game state and the number of clock
//   edges since that state was entered, and derives lights, race time and
//   position-update instants from that elapsed count arithmetically.
module tb_race_control;

  localparam int TD = 4;
  localparam int LM = 3;
  localparam int MM = 2;
  localparam int XS = 256;
  localparam int TE = 280;
  localparam int MX = 7;

  logic clk = 1'b0;
  logic reset;

  race_control_if bus ();

  race_control #(
    .TICK_DIV (TD),
    .LIGHT_MS (LM),
    .MOVE_MS  (MM),
    .X_START  (XS),
    .TRACK_END(TE),
    .MAX_SPEED(MX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int totalCount = 0;
  int failCount  = 0;

  int mState, mN, mLights, mGreen, mWin, mFs1, mFs2, mMs;
  int mX1, mX2, mSp1, mSp2;

  // Single comparison with an immediate assertion.
  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mN = 0; mLights = 0; mGreen = 0; mWin = 0;
    mFs1 = 0; mFs2 = 0; mMs = 0; mX1 = XS; mX2 = XS; mSp1 = 0; mSp2 = 0;
  endtask

  task automatic modelEnter(input int s);
    mState = s;
    mN     = 0;
  endtask

  task automatic modelNewRace();
    mLights = 0; mGreen = 0; mWin = 0; mFs1 = 0; mFs2 = 0; mMs = 0;
    mX1 = XS; mX2 = XS; mSp1 = 0; mSp2 = 0;
    modelEnter(1);
  endtask

  // Model for one clock edge, given the inputs present before it.
  task automatic modelStep(input bit sg, input bit ab, input bit k1, input bit k2);
    int ticks, n1, n2;
    bit h1, h2;
    if (ab) begin
      modelReset();
    end else begin
      case (mState)
        0, 3: begin
          if (sg) modelNewRace();
          else mN++;
        end
        1: begin
          if (k1 || k2) begin
            mFs1 = k1; mFs2 = k2;
            mWin = (k1 && k2) ? 0 : (k1 ? 2 : 1);
            modelEnter(3);
          end else begin
            mN++;
            ticks = mN / TD;
            if (ticks >= 4 * LM) begin
              mLights = 3; mGreen = 1;
              modelEnter(2);
            end else begin
              mLights = ticks / LM;
            end
          end
        end
        default: begin
          mN++;
          ticks = mN / TD;
          mMs = (ticks > 65535) ? 65535 : ticks;
          // positions move one edge after every MM-th tick
          if (mN > 1 && ((mN - 1) % (TD * MM)) == 0) begin
            n1 = mX1 + mSp1; n2 = mX2 + mSp2;
            h1 = (n1 >= TE); h2 = (n2 >= TE);
            mX1 = h1 ? TE : n1;
            mX2 = h2 ? TE : n2;
            if (h1 || h2) begin
              mWin = (h1 && h2) ? 3 : (h1 ? 1 : 2);
              mGreen = 0;
              modelEnter(3);
            end
          end
          if (k1 && mSp1 < MX) mSp1++;
          if (k2 && mSp2 < MX) mSp2++;
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".state"},   32'(bus.state),          32'(mState));
    check1({tag, ".lights"},  32'(bus.lights),         32'(mLights));
    check1({tag, ".green"},   32'(bus.green),          32'(mGreen));
    check1({tag, ".winner"},  32'(bus.winner),         32'(mWin));
    check1({tag, ".fs1"},     32'(bus.false_start_p1), 32'(mFs1));
    check1({tag, ".fs2"},     32'(bus.false_start_p2), 32'(mFs2));
    check1({tag, ".race_ms"}, 32'(bus.race_ms),        32'(mMs));
    check1({tag, ".xpos_p1"}, 32'(bus.xpos_p1),        32'(mX1));
    check1({tag, ".xpos_p2"}, 32'(bus.xpos_p2),        32'(mX2));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input string tag, input bit sg, input bit ab,
                               input bit k1, input bit k2);
    @(negedge clk);
    bus.start_game = sg;
    bus.abort      = ab;
    bus.p1_key     = k1;
    bus.p2_key     = k2;
    modelStep(sg, ab, k1, k2);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic runCountdown(input string tag, input int steps);
    applyStimulus({tag, "_start"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= steps; i++) begin
      applyStimulus({tag, "_cd"}, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 12) check1({tag, "_lights_at12"}, 32'(bus.lights), 32'd1);
      if (i == 48) check1({tag, "_state_at48"}, 32'(bus.state), 32'd2);
    end
  endtask

  task automatic runToFinish(input string tag);
    for (int g = 0; g < 300 && mState == 2; g++) begin
      applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check1({tag, "_reached_finish"}, 32'(bus.state), 32'd3);
  endtask

  int div;
  bit rk1, rk2;

  initial begin
    bus.start_game = 1'b0;
    bus.abort      = 1'b0;
    bus.p1_key     = 1'b0;
    bus.p2_key     = 1'b0;
    reset          = 1'b1;
    modelReset();
    #3;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    // keys in idle are ignored
    for (int i = 0; i < 6; i++) begin
      applyStimulus("idle_keys", 1'b0, 1'b0, i[0], i[1]);
    end

    // countdown then race: P1 speed 3, P2 speed 1
    runCountdown("race1", 48);
    check1("race1_green", 32'(bus.green), 32'd1);
    applyStimulus("race1_keys", 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus("race1_keys", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("race1_keys", 1'b0, 1'b0, 1'b1, 1'b0);
    runToFinish("race1_run");
    check1("race1_winner", 32'(bus.winner), 32'd1);
    check1("race1_x1", 32'(bus.xpos_p1), 32'd280);
    check1("race1_x2", 32'(bus.xpos_p2), 32'd264);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("finish_keys", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check1("race1_ms_frozen", 32'(bus.race_ms), 32'd16);

    // false start by P2 while one light is lit
    runCountdown("fs", 12);
    applyStimulus("fs_key", 1'b0, 1'b0, 1'b0, 1'b1);
    check1("fs_flag2", 32'(bus.false_start_p2), 32'd1);
    check1("fs_winner", 32'(bus.winner), 32'd1);
    check1("fs_state", 32'(bus.state), 32'd3);
    check1("fs_x1", 32'(bus.xpos_p1), 32'd256);

    // saturation and tie
    runCountdown("tie", 48);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("tie_keys", 1'b0, 1'b0, 1'b1, 1'b1);
    end
    runToFinish("tie_run");
    check1("tie_winner", 32'(bus.winner), 32'd3);
    check1("tie_x1", 32'(bus.xpos_p1), 32'd280);
    check1("tie_x2", 32'(bus.xpos_p2), 32'd280);

    // abort beats a simultaneous start_game, then restart
    runCountdown("ab", 48);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("ab_race", 1'b0, 1'b0, 1'b1, i[0]);
    end
    applyStimulus("ab_abort", 1'b1, 1'b1, 1'b0, 1'b0);
    check1("ab_state", 32'(bus.state), 32'd0);
    check1("ab_x1", 32'(bus.xpos_p1), 32'd256);
    applyStimulus("ab_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    check1("ab_restart_state", 32'(bus.state), 32'd1);
    for (int i = 0; i < 48; i++) begin
      applyStimulus("ab_cd", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus("rst_race", 1'b0, 1'b0, i[0], i[1]);
    end

    // asynchronous reset mid-race
    #2;
    reset          = 1'b1;
    bus.start_game = 1'b0;
    bus.abort      = 1'b0;
    bus.p1_key     = 1'b0;
    bus.p2_key     = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    check1("async_reset_x2", 32'(bus.xpos_p2), 32'd256);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("post_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check1("post_reset_state", 32'(bus.state), 32'd0);

    // randomized play with varying key rates
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: div = 100;
        1: div = 6;
        2: div = 1000;
        default: div = 20;
      endcase
      for (int i = 0; i < 250; i++) begin
        rk1 = ($urandom % div) == 0;
        rk2 = ($urandom % div) == 0;
        applyStimulus("random", ($urandom % 40) == 0, ($urandom % 150) == 0, rk1, rk2);
      end
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
